// File: rtl/mem_pkg.sv
// Shared definitions for the byte-addressed data memory: access sizes,
// FSM state type and the alignment rule.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Width of the wait-state counter (WAIT_STATES ranges 0..15)
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  // Natural alignment check; size 2'b11 is never legal
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~addr_lo[0];
      SIZE_WORD: ok = (addr_lo == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational big-endian lane steering for the data memory.
// Lane k (k = byte offset within the word) lives in word bits [31-8k -: 8].
// Store side: byte enables per lane plus replicated store data.
// Load side: byte/half extraction with sign or zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store: replicate the right-justified datum into every lane, enable only target lanes
  always_comb begin
    o_be    = '0;
    o_wword = i_wdata;
    case (i_size)
      SIZE_BYTE: begin
        o_wword = {4{i_wdata[7:0]}};
        o_be    = 4'b0001 << i_addr_lo;
      end
      SIZE_HALF: begin
        o_wword = {2{i_wdata[15:0]}};
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      SIZE_WORD: o_be = 4'b1111;
      default:   o_be = '0;
    endcase
  end

  // Load lane select: pick the addressed byte and half out of the word
  always_comb begin
    w_byte = i_rword[31:24];
    case (i_addr_lo)
      2'd0: w_byte = i_rword[31:24];
      2'd1: w_byte = i_rword[23:16];
      2'd2: w_byte = i_rword[15:8];
      2'd3: w_byte = i_rword[7:0];
      default: w_byte = i_rword[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rword[15:0] : i_rword[31:16];
  end

  // Load extension: right-justify and sign/zero extend sub-word results
  always_comb begin
    o_rdata = i_rword;
    case (i_size)
      SIZE_BYTE: o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SIZE_HALF: o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
      default:   o_rdata = i_rword;
    endcase
  end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressed data memory for the MEM stage: byte/half/word loads and
// stores, big-endian lanes, alignment errors, configurable wait states and
// a valid/ready request handshake. The byte array is never reset.
module byte_data_memory
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic        rsp_valid,
  output logic [31:0] readData,
  output logic        rsp_err
);

  localparam int unsigned      DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES - 1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_pending;
  logic                    r_write;
  logic [1:0]              r_size;
  logic                    r_unsigned;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [31:0]             r_wdata;

  logic                    w_accept;
  logic                    w_complete;
  logic                    w_err;
  logic [ADDR_WIDTH-3:0]   w_wbase;
  logic [31:0]             w_rword;
  logic [3:0]              w_be;
  logic [31:0]             w_wword;
  logic [31:0]             w_rdata;
  logic                    w_unused_addr;

  logic [7:0]              mem [0:DEPTH-1];

  assign req_ready     = (r_state == IDLE);
  assign w_accept      = req_valid & req_ready;
  // A captured request completes on the first edge seen in IDLE; with no wait
  // states this overlaps the next accept, giving one request per cycle.
  assign w_complete    = r_pending & (r_state == IDLE);
  assign w_err         = ~is_aligned(r_size, r_addr[1:0]);
  assign w_wbase       = r_addr[ADDR_WIDTH-1:2];
  assign w_unused_addr = ^address[31:ADDR_WIDTH];

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next-state: enter WAIT on accept only when wait states are configured
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept && (WAIT_STATES > 0)) w_next_state = WAIT;
      WAIT:    if (r_cnt == CNT_LAST) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Wait-state counter, runs only while in WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_cnt <= '0;
    else if (r_state == WAIT)   r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    else                        r_cnt <= '0;
  end

  // Request capture on accept; reset drops any pending request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending  <= 1'b0;
      r_write    <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_pending  <= 1'b1;
      r_write    <= req_write;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= address[ADDR_WIDTH-1:0];
      r_wdata    <= writeData;
    end else if (w_complete) begin
      r_pending  <= 1'b0;
    end
  end

  // Assemble the addressed word, lane 0 in the most significant byte
  always_comb begin
    w_rword = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_rword[8*(3-k) +: 8] = mem[{w_wbase, k[1:0]}];
    end
  end

  mem_lane_align u_lane_align (
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_addr_lo  (r_addr[1:0]),
    .i_wdata    (r_wdata),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wword    (w_wword),
    .o_rdata    (w_rdata)
  );

  // Store commit on the completing edge; errored requests never write
  always_ff @(posedge clk) begin
    if (w_complete && r_write && !w_err) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (w_be[k]) mem[{w_wbase, k[1:0]}] <= w_wword[8*(3-k) +: 8];
      end
    end
  end

  // Response registers: one-cycle pulse, data only for good loads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      readData  <= '0;
    end else begin
      rsp_valid <= w_complete;
      rsp_err   <= w_complete & w_err;
      readData  <= (w_complete && !w_err && !r_write) ? w_rdata : '0;
    end
  end

endmodule

// File: tb/tb_byte_data_memory.sv
// Bench for byte_data_memory: one instance with no wait states, one with
// three, both checked against a byte-array reference model.
module tb_byte_data_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_valid, a_ready, a_write, a_uns, a_rv, a_err;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wd, a_rd;
  logic        b_reset, b_valid, b_ready, b_write, b_uns, b_rv, b_err;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wd, b_rd;

  byte_data_memory #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .reset(a_reset), .req_valid(a_valid), .req_ready(a_ready),
    .req_write(a_write), .req_size(a_size), .req_unsigned(a_uns),
    .address(a_addr), .writeData(a_wd), .rsp_valid(a_rv), .readData(a_rd),
    .rsp_err(a_err)
  );

  byte_data_memory #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_w3 (
    .clk(clk), .reset(b_reset), .req_valid(b_valid), .req_ready(b_ready),
    .req_write(b_write), .req_size(b_size), .req_unsigned(b_uns),
    .address(b_addr), .writeData(b_wd), .rsp_valid(b_rv), .readData(b_rd),
    .rsp_err(b_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] mdl [2][1024];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: bytes stored MSB-first starting at the address, modulo 1 KiB
  task automatic model(input bit sel, input bit wr, input logic [1:0] sz, input bit un,
                       input logic [31:0] ad, input logic [31:0] wd,
                       output logic [31:0] ed, output bit ee);
    int a;
    int nb;
    logic [31:0] v;
    a  = int'(ad % 1024);
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ee = (sz == 2'd3) || ((a % nb) != 0);
    ed = '0;
    if (ee) return;
    if (wr) begin
      for (int i = 0; i < nb; i++) mdl[sel][10'(a + i)] = 8'(wd >> (8 * (nb - 1 - i)));
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v = (v << 8) | 32'(mdl[sel][10'(a + i)]);
      if (!un && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      ed = v;
    end
  endtask

  task automatic drive(input bit sel, input bit v, input bit wr, input logic [1:0] sz,
                       input bit un, input logic [31:0] ad, input logic [31:0] wd);
    if (sel) begin
      b_valid = v; b_write = wr; b_size = sz; b_uns = un; b_addr = ad; b_wd = wd;
    end else begin
      a_valid = v; a_write = wr; a_size = sz; a_uns = un; a_addr = ad; a_wd = wd;
    end
  endtask

  // {ready, rsp_valid, rsp_err, readData}
  function automatic logic [34:0] peek(input bit sel);
    return sel ? {b_ready, b_rv, b_err, b_rd} : {a_ready, a_rv, a_err, a_rd};
  endfunction

  task automatic txn(input bit sel, input bit wr, input logic [1:0] sz, input bit un,
                     input logic [31:0] ad, input logic [31:0] wd, input string tag,
                     output logic [31:0] rd);
    logic [31:0] ed;
    bit ee;
    bit acc;
    bit rdy;
    int lat;
    logic [34:0] p;
    model(sel, wr, sz, un, ad, wd, ed, ee);
    drive(sel, 1'b1, wr, sz, un, ad, wd);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      p = peek(sel);
      rdy = p[34];
      @(posedge clk); #1;
      acc = rdy;
    end
    drive(sel, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check({tag, "/accept"}, 32'(acc), 32'd1);
    lat = 0;
    p = peek(sel);
    while (!p[33] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      p = peek(sel);
    end
    check({tag, "/latency"}, 32'(lat), sel ? 32'd4 : 32'd1);
    check({tag, "/err"}, 32'(p[32]), 32'(ee));
    check({tag, "/data"}, p[31:0], ed);
    rd = p[31:0];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] ed;
    logic [31:0] ed2;
    bit ee;
    bit seen;
    logic [34:0] p;
    logic [1:0] sz;
    logic [31:0] ad;

    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    a_reset = 1'b1;
    b_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      p = peek(s[0]);
      check("reset/ready", 32'(p[34]), 32'd1);
      check("reset/rsp_valid", 32'(p[33]), 32'd0);
      check("reset/rsp_err", 32'(p[32]), 32'd0);
      check("reset/readData", p[31:0], 32'd0);
    end
    a_reset = 1'b0;
    b_reset = 1'b0;
    @(posedge clk); #1;

    // Fill the working window 0x00..0x3F on both instances
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 16; w++)
        txn(s[0], 1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom, "init", r);

    // Back-to-back SW then LW with no wait states
    model(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, ed, ee);
    model(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, ed2, ee);
    drive(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("t1/rv_before", 32'(a_rv), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(posedge clk); #1;
    check("t1/sw_rv", 32'(a_rv), 32'd1);
    check("t1/sw_data", a_rd, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check("t1/lw_rv", 32'(a_rv), 32'd1);
    check("t1/lw_data", a_rd, 32'hDEADBEEF);
    check("t1/lw_model", a_rd, ed2);
    @(posedge clk); #1;
    check("t1/rv_after", 32'(a_rv), 32'd0);

    // Sub-word loads with extension
    txn(1'b0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, "t2/lb", r);   check("t2/lb_val", r, 32'hFFFFFFDE);
    txn(1'b0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, "t2/lbu", r);  check("t2/lbu_val", r, 32'h000000EF);
    txn(1'b0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, "t2/lh", r);   check("t2/lh_val", r, 32'hFFFFBEEF);
    txn(1'b0, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, "t2/lhu", r);  check("t2/lhu_val", r, 32'h0000DEAD);

    // Sub-word stores merge into the word
    txn(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h12345678, "t3/sb", r);
    txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "t3/lw1", r);  check("t3/lw1_val", r, 32'hDE78BEEF);
    txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hAAAA5555, "t3/sh", r);
    txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "t3/lw2", r);  check("t3/lw2_val", r, 32'hDE785555);

    // Misaligned and illegal requests
    txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, "t4/lw_mis", r);
    check("t4/lw_mis_err", 32'(a_err), 32'd1);
    txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFFFFFF, "t4/sh_mis", r);
    check("t4/sh_mis_err", 32'(a_err), 32'd1);
    txn(1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, "t4/size3", r);
    check("t4/size3_err", 32'(a_err), 32'd1);
    check("t4/size3_data", r, 32'd0);
    txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "t4/lw", r);   check("t4/lw_val", r, 32'hDE785555);

    // Upper address bits alias onto the same bytes
    txn(1'b0, 1'b0, 2'b10, 1'b0, 32'hFFFFFC10, 32'h0, "alias", r); check("alias_val", r, 32'hDE785555);

    // Randomised traffic on both instances
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 40; i++) begin
        sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        ad = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63));
        if ((i % 4) != 0) begin
          if (sz == 2'b01) ad[0] = 1'b0;
          else if (sz == 2'b10) ad[1:0] = 2'b00;
        end
        txn(s[0], 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, "rand", r);
      end
    end

    // Wait-state timing with req_valid held across the busy window
    model(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, ed, ee);
    model(1'b1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, ed2, ee);
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
    for (int k = 0; k < 3; k++) begin
      check("t5/ready_low", 32'(b_ready), 32'd0);
      check("t5/rv_low", 32'(b_rv), 32'd0);
      @(posedge clk); #1;
    end
    check("t5/ready_high", 32'(b_ready), 32'd1);
    check("t5/rv_early", 32'(b_rv), 32'd0);
    @(posedge clk); #1;
    check("t5/rv1", 32'(b_rv), 32'd1);
    check("t5/data1", b_rd, ed);
    check("t5/ready_busy2", 32'(b_ready), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("t5/ready_high2", 32'(b_ready), 32'd1);
    check("t5/rv_gap", 32'(b_rv), 32'd0);
    @(posedge clk); #1;
    check("t5/rv2", 32'(b_rv), 32'd1);
    check("t5/data2", b_rd, ed2);

    // Reset during WAIT drops the pending store
    model(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, ed, ee);
    drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check("t6/ready_wait", 32'(b_ready), 32'd0);
    @(posedge clk); #1;
    b_reset = 1'b1;
    #1;
    check("t6/ready_async", 32'(b_ready), 32'd1);
    check("t6/rv_async", 32'(b_rv), 32'd0);
    @(posedge clk); #1;
    b_reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (b_rv) seen = 1'b1;
    end
    check("t6/no_rsp", 32'(seen), 32'd0);
    txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "t6/lw", r);
    check("t6/old_value", r, ed);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
